// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register storage with two registered read ports, write bypass and a busy scoreboard
module register_file #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_en,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             ra_busy,
  output logic             rb_busy,
  input  logic             bs_en,
  input  logic [AW-1:0]    bs_addr,
  output logic [DEPTH-1:0] busy_vec
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic             we, se, ra_hit, rb_hit;
  logic [WIDTH-1:0] ra_nxt, rb_nxt;
  // Register 0 stays at its reset value and never goes busy when hardwired to zero
  assign we = w_en && !(ZERO_R0 != 0 && w_addr == '0);
  assign se = bs_en && !(ZERO_R0 != 0 && bs_addr == '0);
  assign ra_hit = BYPASS != 0 && we && ra_addr == w_addr;
  assign rb_hit = BYPASS != 0 && we && rb_addr == w_addr;
  assign ra_nxt = ra_hit ? w_data : mem[ra_addr];
  assign rb_nxt = rb_hit ? w_data : mem[rb_addr];
  assign busy_vec = busy;
  // A new issue on the retiring register overrides the clear
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[w_addr] = 1'b0;
    if (se) busy_nxt[bs_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy    <= '0;
      ra_data <= '0;
      rb_data <= '0;
      ra_busy <= 1'b0;
      rb_busy <= 1'b0;
    end else begin
      if (we) mem[w_addr] <= w_data;
      busy <= busy_nxt;
      if (r_en) begin
        ra_data <= ra_nxt;
        rb_data <= rb_nxt;
        ra_busy <= !ra_hit && busy[ra_addr];
        rb_busy <= !rb_hit && busy[rb_addr];
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file in default, no-bypass/zero-r0 and 32x32 builds
module tb_register_file;
  logic clk = 0, rst = 1;
  logic w_en = 0, r_en = 0, bs_en = 0;
  logic [2:0] w_addr = 0, ra_addr = 0, rb_addr = 0, bs_addr = 0;
  logic [7:0] w_data = 0;
  logic [7:0] a_ra, a_rb, b_ra, b_rb, a_bv, b_bv;
  logic a_rab, a_rbb, b_rab, b_rbb;
  logic c_w_en = 0, c_r_en = 0;
  logic [4:0] c_w_addr = 0, c_ra_addr = 0, c_rb_addr = 0;
  logic [31:0] c_w_data = 0, c_ra, c_rb, c_bv;
  logic c_rab, c_rbb;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  register_file u_a (.clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(a_ra), .rb_data(a_rb),
    .ra_busy(a_rab), .rb_busy(a_rbb), .bs_en(bs_en), .bs_addr(bs_addr), .busy_vec(a_bv));
  register_file #(.BYPASS(0), .ZERO_R0(1)) u_b (.clk(clk), .rst(rst), .w_en(w_en),
    .w_addr(w_addr), .w_data(w_data), .r_en(r_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(b_ra), .rb_data(b_rb), .ra_busy(b_rab), .rb_busy(b_rbb), .bs_en(bs_en),
    .bs_addr(bs_addr), .busy_vec(b_bv));
  register_file #(.WIDTH(32), .DEPTH(32)) u_c (.clk(clk), .rst(rst), .w_en(c_w_en),
    .w_addr(c_w_addr), .w_data(c_w_data), .r_en(c_r_en), .ra_addr(c_ra_addr),
    .rb_addr(c_rb_addr), .ra_data(c_ra), .rb_data(c_rb), .ra_busy(c_rab), .rb_busy(c_rbb),
    .bs_en(1'b0), .bs_addr(5'd0), .busy_vec(c_bv));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 0; r_en = 0; bs_en = 0;
  endtask

  task automatic test_reset();
    idle();
    w_en = 1; w_addr = 3; w_data = 8'hA5; bs_en = 1; bs_addr = 6;
    tick();
    idle();
    total++; if (a_bv !== 8'h40) begin bad++; $display("FAIL pre_reset_busy got %h want 40", a_bv); end
    rst = 1; w_en = 1; w_addr = 3; w_data = 8'h5A; r_en = 1; ra_addr = 3; bs_en = 1; bs_addr = 2;
    tick();
    rst = 0; idle();
    total++; if (a_ra !== 8'h00) begin bad++; $display("FAIL reset_ra got %h want 00", a_ra); end
    total++; if (c_bv !== 32'h0) begin bad++; $display("FAIL reset_c_busy got %h want 0", c_bv); end
    r_en = 1; ra_addr = 3; rb_addr = 6;
    tick();
    idle();
    total++; if (a_ra !== 8'h00) begin bad++; $display("FAIL reset_r3 got %h want 00", a_ra); end
    total++; if (a_bv !== 8'h00) begin bad++; $display("FAIL reset_busy got %h want 00", a_bv); end
    total++; if (a_rbb !== 1'b0) begin bad++; $display("FAIL reset_rb_busy got %b want 0", a_rbb); end
    total++; if (b_ra !== 8'h00) begin bad++; $display("FAIL reset_b_r3 got %h want 00", b_ra); end
  endtask

  task automatic test_dual_read();
    w_en = 1; w_addr = 1; w_data = 8'h11;
    tick();
    w_addr = 2; w_data = 8'h22;
    tick();
    idle();
    r_en = 1; ra_addr = 1; rb_addr = 2;
    tick();
    idle();
    total++; if (a_ra !== 8'h11) begin bad++; $display("FAIL dual_ra got %h want 11", a_ra); end
    total++; if (a_rb !== 8'h22) begin bad++; $display("FAIL dual_rb got %h want 22", a_rb); end
    total++; if (b_ra !== 8'h11) begin bad++; $display("FAIL dual_b_ra got %h want 11", b_ra); end
    ra_addr = 2; rb_addr = 1;
    tick();
    total++; if (a_ra !== 8'h11 || a_rb !== 8'h22) begin bad++; $display("FAIL hold got %h/%h want 11/22", a_ra, a_rb); end
    r_en = 1; ra_addr = 2; rb_addr = 2;
    tick();
    idle();
    total++; if (a_ra !== 8'h22 || a_rb !== 8'h22) begin bad++; $display("FAIL same_addr got %h/%h want 22/22", a_ra, a_rb); end
  endtask

  task automatic test_bypass();
    w_en = 1; w_addr = 4; w_data = 8'h10;
    tick();
    w_data = 8'h55; r_en = 1; ra_addr = 4; rb_addr = 1;
    tick();
    idle();
    total++; if (a_ra !== 8'h55) begin bad++; $display("FAIL bypass_on got %h want 55", a_ra); end
    total++; if (b_ra !== 8'h10) begin bad++; $display("FAIL bypass_off got %h want 10", b_ra); end
    total++; if (a_rb !== 8'h11 || b_rb !== 8'h11) begin bad++; $display("FAIL bypass_other got %h/%h want 11/11", a_rb, b_rb); end
    r_en = 1; ra_addr = 4;
    tick();
    idle();
    total++; if (a_ra !== 8'h55 || b_ra !== 8'h55) begin bad++; $display("FAIL after_bypass got %h/%h want 55/55", a_ra, b_ra); end
  endtask

  task automatic test_scoreboard();
    bs_en = 1; bs_addr = 5;
    tick();
    idle();
    total++; if (a_bv !== 8'h20) begin bad++; $display("FAIL busy_set got %h want 20", a_bv); end
    r_en = 1; ra_addr = 5;
    tick();
    idle();
    total++; if (a_rab !== 1'b1) begin bad++; $display("FAIL read_busy got %b want 1", a_rab); end
    w_en = 1; w_addr = 5; w_data = 8'h77;
    tick();
    idle();
    total++; if (a_bv !== 8'h00) begin bad++; $display("FAIL busy_clear got %h want 00", a_bv); end
    total++; if (a_rab !== 1'b1) begin bad++; $display("FAIL busy_hold got %b want 1", a_rab); end
    w_en = 1; w_addr = 5; w_data = 8'h78; bs_en = 1; bs_addr = 5; r_en = 1; ra_addr = 5;
    tick();
    idle();
    total++; if (a_bv !== 8'h20 || b_bv !== 8'h20) begin bad++; $display("FAIL set_wins got %h/%h want 20/20", a_bv, b_bv); end
    total++; if (a_rab !== 1'b0 || a_ra !== 8'h78) begin bad++; $display("FAIL collide_read got %b/%h want 0/78", a_rab, a_ra); end
    total++; if (b_rab !== 1'b0 || b_ra !== 8'h77) begin bad++; $display("FAIL collide_nobyp got %b/%h want 0/77", b_rab, b_ra); end
    w_en = 1; w_addr = 5; w_data = 8'h79; r_en = 1; ra_addr = 5;
    tick();
    idle();
    total++; if (a_rab !== 1'b0 || a_ra !== 8'h79) begin bad++; $display("FAIL retire_byp got %b/%h want 0/79", a_rab, a_ra); end
    total++; if (b_rab !== 1'b1 || b_ra !== 8'h78) begin bad++; $display("FAIL retire_nobyp got %b/%h want 1/78", b_rab, b_ra); end
    total++; if (a_bv !== 8'h00 || b_bv !== 8'h00) begin bad++; $display("FAIL retire_vec got %h/%h want 00/00", a_bv, b_bv); end
  endtask

  task automatic test_zero_r0();
    w_en = 1; w_addr = 0; w_data = 8'hFF; bs_en = 1; bs_addr = 0;
    tick();
    idle();
    total++; if (b_bv[0] !== 1'b0) begin bad++; $display("FAIL zero_busy got %b want 0", b_bv[0]); end
    total++; if (a_bv !== 8'h01) begin bad++; $display("FAIL r0_busy got %h want 01", a_bv); end
    r_en = 1; ra_addr = 0; rb_addr = 0;
    tick();
    idle();
    total++; if (b_ra !== 8'h00 || b_rab !== 1'b0) begin bad++; $display("FAIL zero_read got %h/%b want 00/0", b_ra, b_rab); end
    total++; if (a_ra !== 8'hFF || a_rab !== 1'b1) begin bad++; $display("FAIL r0_read got %h/%b want ff/1", a_ra, a_rab); end
    w_en = 1; w_addr = 0; w_data = 8'hEE; r_en = 1; ra_addr = 0; rb_addr = 0;
    tick();
    idle();
    total++; if (b_ra !== 8'h00 || b_rb !== 8'h00 || b_rab !== 1'b0) begin bad++; $display("FAIL zero_bypass got %h/%h/%b want 00/00/0", b_ra, b_rb, b_rab); end
    total++; if (a_ra !== 8'hEE || a_rab !== 1'b0 || a_bv !== 8'h00) begin bad++; $display("FAIL r0_bypass got %h/%b/%h want ee/0/00", a_ra, a_rab, a_bv); end
  endtask

  task automatic test_param();
    logic [31:0] ea, eb;
    for (int i = 0; i < 32; i++) begin
      c_w_en = 1; c_w_addr = 5'(i); c_w_data = 32'(i) ^ 32'hDEADBEEF;
      tick();
    end
    c_w_en = 0;
    for (int i = 0; i < 32; i++) begin
      c_r_en = 1; c_ra_addr = 5'(i); c_rb_addr = 5'(31 - i);
      ea = 32'(i) ^ 32'hDEADBEEF; eb = 32'(31 - i) ^ 32'hDEADBEEF;
      tick();
      total++; if (c_ra !== ea || c_rb !== eb) begin bad++; $display("FAIL wide_read[%0d] got %h/%h want %h/%h", i, c_ra, c_rb, ea, eb); end
    end
    c_r_en = 0;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    test_reset();
    test_dual_read();
    test_bypass();
    test_scoreboard();
    test_zero_r0();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
